// File: rtl/omr_sheet_scanner.sv
// omr_sheet_scanner: thresholds the serial bubble-sample stream (sheet_start, sample_valid/sample_ready, sample_data in) into a one-hot answer word plus blank/multi masks and answered count (answers, blank_mask, multi_mask, answered_cnt, out_valid/out_ready out)
module omr_sheet_scanner #(
  parameter int NUM_Q = 10,
  parameter int NUM_OPT = 4,
  parameter int SAMPLE_W = 8,
  parameter logic [SAMPLE_W-1:0] DARK_THRESH = 8'd128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sheet_start,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [SAMPLE_W-1:0]      sample_data,
  output logic [NUM_Q*NUM_OPT-1:0] answers,
  output logic [NUM_Q-1:0]         blank_mask,
  output logic [NUM_Q-1:0]         multi_mask,
  output logic [3:0]               answered_cnt,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int QW = $clog2(NUM_Q);
  localparam int OW = $clog2(NUM_OPT);
  localparam int CW = $clog2(NUM_OPT + 1);
  localparam int AW = $clog2(NUM_Q * NUM_OPT);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state_q, state_d;
  logic [OW-1:0] opt_q, opt_d;
  logic [QW-1:0] q_q, q_d;
  logic [NUM_OPT-1:0] vec_q, vec_d, vec_nx;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [NUM_Q*NUM_OPT-1:0] answers_q, answers_d;
  logic [NUM_Q-1:0] blank_q, blank_d, multi_q, multi_d;
  logic [3:0] answered_q, answered_d;
  logic out_valid_q, out_valid_d;
  logic dark, accept, last_opt, last_q;
  logic [AW-1:0] base;
  always_comb begin
    dark = sample_data >= DARK_THRESH;
    accept = sample_valid && state_q == SCAN;
    vec_nx = vec_q | (NUM_OPT'(dark) << opt_q);
    cnt_nx = cnt_q + CW'(dark && cnt_q != CW'(NUM_OPT));
    last_opt = opt_q == OW'(NUM_OPT - 1);
    last_q = q_q == QW'(NUM_Q - 1);
    base = AW'(q_q) * AW'(NUM_OPT);
    state_d = state_q;
    opt_d = opt_q;
    q_d = q_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    answers_d = answers_q;
    blank_d = blank_q;
    multi_d = multi_q;
    answered_d = answered_q;
    out_valid_d = out_valid_q;
    if (sheet_start && state_q != HOLD) begin
      // start and restart both clear everything; a sample in the same cycle is dropped
      state_d = SCAN;
      opt_d = '0;
      q_d = '0;
      vec_d = '0;
      cnt_d = '0;
      answers_d = '0;
      blank_d = '0;
      multi_d = '0;
      answered_d = '0;
    end else if (accept) begin
      opt_d = last_opt ? '0 : opt_q + 1'b1;
      vec_d = last_opt ? '0 : vec_nx;
      cnt_d = last_opt ? '0 : cnt_nx;
      if (last_opt) begin
        // commit uses the last option's sample folded into vec_nx/cnt_nx
        answers_d[base +: NUM_OPT] = cnt_nx == CW'(1) ? vec_nx : '0;
        blank_d[q_q] = cnt_nx == '0;
        multi_d[q_q] = cnt_nx > CW'(1);
        answered_d = answered_q + 4'(cnt_nx == CW'(1));
        q_d = last_q ? '0 : q_q + 1'b1;
        state_d = last_q ? HOLD : SCAN;
        out_valid_d = last_q;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opt_q <= '0;
      q_q <= '0;
      vec_q <= '0;
      cnt_q <= '0;
      answers_q <= '0;
      blank_q <= '0;
      multi_q <= '0;
      answered_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opt_q <= opt_d;
      q_q <= q_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      answers_q <= answers_d;
      blank_q <= blank_d;
      multi_q <= multi_d;
      answered_q <= answered_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign sample_ready = state_q == SCAN;
  assign answers = answers_q;
  assign blank_mask = blank_q;
  assign multi_mask = multi_q;
  assign answered_cnt = answered_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_omr_sheet_scanner.sv
// tb_omr_sheet_scanner: directed scenarios against a sheet-level reference model
module tb_omr_sheet_scanner;
  logic clk = 0, reset = 1, sheet_start = 0, sample_valid = 0, out_ready = 0;
  logic [7:0] sample_data = 0;
  logic sample_ready, out_valid;
  logic [39:0] answers;
  logic [9:0] blank_mask, multi_mask;
  logic [3:0] answered_cnt;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic [7:0] sh [40];
  typedef enum {M_IDLE, M_SCAN, M_HOLD} mode_t;
  mode_t mode = M_IDLE;
  logic [7:0] mq [$];
  logic [39:0] m_ans = 0;
  logic [9:0] m_blank = 0, m_multi = 0;
  logic [3:0] m_cnt = 0;

  omr_sheet_scanner dut (
    .clk(clk), .reset(reset), .sheet_start(sheet_start), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_data(sample_data), .answers(answers),
    .blank_mask(blank_mask), .multi_mask(multi_mask), .answered_cnt(answered_cnt),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    m_ans = '0;
    m_blank = '0;
    m_multi = '0;
    m_cnt = '0;
    mq.delete();
  endfunction

  function automatic void m_grade();
    for (int q = 0; q < 10; q++) begin
      int n;
      logic [3:0] v;
      n = 0;
      v = '0;
      for (int o = 0; o < 4; o++)
        if (mq[4*q+o] >= 8'd128) begin
          n++;
          v[o] = 1'b1;
        end
      if (n == 1) begin
        m_ans[4*q +: 4] = v;
        m_cnt = m_cnt + 4'd1;
      end else if (n == 0) m_blank[q] = 1'b1;
      else m_multi[q] = 1'b1;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      mode = M_IDLE;
      m_clear();
    end else case (mode)
      M_IDLE: if (sheet_start) begin mode = M_SCAN; m_clear(); end
      M_SCAN: if (sheet_start) m_clear();
              else if (sample_valid) begin
                mq.push_back(sample_data);
                if (mq.size() == 40) begin m_grade(); mode = M_HOLD; end
              end
      M_HOLD: if (out_ready) mode = M_IDLE;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("sample_ready", sample_ready, mode == M_SCAN);
      check("out_valid", out_valid, mode == M_HOLD);
      if (mode != M_SCAN) begin
        check("answers", answers, m_ans);
        check("blank_mask", blank_mask, m_blank);
        check("multi_mask", multi_mask, m_multi);
        check("answered_cnt", answered_cnt, m_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_sheet();
    sheet_start = 1;
    @(negedge clk);
    sheet_start = 0;
  endtask

  task automatic send(int n, int gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      sample_valid = 1;
      sample_data = sh[i];
      @(negedge clk);
      sample_valid = 0;
      sample_data = 0;
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic lit(string nm, logic [39:0] a, logic [9:0] b, logic [9:0] m, logic [3:0] n);
    check({nm, "_answers"}, answers, a);
    check({nm, "_blank"}, blank_mask, b);
    check({nm, "_multi"}, multi_mask, m);
    check({nm, "_cnt"}, answered_cnt, n);
    check({nm, "_model_answers"}, m_ans, a);
    check({nm, "_model_blank"}, m_blank, b);
    check({nm, "_model_multi"}, m_multi, m);
    check({nm, "_model_cnt"}, m_cnt, n);
  endtask

  task automatic build_clean();
    for (int i = 0; i < 40; i++) sh[i] = (i % 4 == (i / 4) % 4) ? 8'd200 : 8'd10;
  endtask

  task automatic build_thresh();
    for (int i = 0; i < 40; i++) sh[i] = 8'd10;
    sh[2] = 8'd127;
    sh[5] = 8'd128;
  endtask

  task automatic build_multi();
    build_clean();
    sh[12] = 8'd200;
    sh[14] = 8'd200;
    sh[15] = 8'd10;
    sh[31] = 8'd10;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk_en = 1;
    check("reset_ready", sample_ready, 0);
    check("reset_valid", out_valid, 0);
    lit("reset", 40'h0, 10'h0, 10'h0, 4'd0);
    build_clean();
    start_sheet();
    send(40, 0);
    check("latency_valid", out_valid, 1);
    wait_valid();
    lit("clean", 40'h21_8421_8421, 10'h0, 10'h0, 4'd10);
    handshake();
    build_thresh();
    start_sheet();
    send(40, 0);
    wait_valid();
    lit("thresh", 40'h20, 10'h3FD, 10'h0, 4'd1);
    handshake();
    build_multi();
    start_sheet();
    send(40, 0);
    wait_valid();
    lit("multi", 40'h21_0421_0421, 10'h080, 10'h008, 4'd8);
    handshake();
    build_clean();
    start_sheet();
    send(40, 0);
    wait_valid();
    for (int k = 0; k < 20; k++) begin
      sample_valid = 1;
      sample_data = 8'd200;
      sheet_start = (k == 5);
      @(negedge clk);
    end
    sample_valid = 0;
    sheet_start = 0;
    check("bp_valid", out_valid, 1);
    check("bp_ready", sample_ready, 0);
    lit("bp", 40'h21_8421_8421, 10'h0, 10'h0, 4'd10);
    handshake();
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", sample_ready, 0);
    lit("post_hs", 40'h21_8421_8421, 10'h0, 10'h0, 4'd10);
    build_thresh();
    start_sheet();
    send(17, 0);
    sheet_start = 1;
    sample_valid = 1;
    sample_data = 8'd200;
    @(negedge clk);
    sheet_start = 0;
    sample_valid = 0;
    sample_data = 0;
    build_multi();
    send(40, 0);
    wait_valid();
    lit("restart", 40'h21_0421_0421, 10'h080, 10'h008, 4'd8);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("reset_hold_valid", out_valid, 0);
    lit("reset_hold", 40'h0, 10'h0, 10'h0, 4'd0);
    build_clean();
    start_sheet();
    send(40, 5);
    wait_valid();
    lit("gapped", 40'h21_8421_8421, 10'h0, 10'h0, 4'd10);
    handshake();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
